sipo_deserializer: RTL

- Parametrised serial-in/parallel-out deserializer and successor to the fixed 4-bit SIPO.
- Accepts one serial bit per accepted handshake, assembles WIDTH-bit words in a selectable bit order, and presents each word on a registered parallel port with valid/ready.
- One staging word plus one output word form a double buffer, so the serial side keeps shifting while the consumer stalls.
- Sits between serial link receivers (UART/SPI-style front ends) and word-wide datapath logic.

---
 rtl/sipo_deserializer_if.sv | 22 ++
 rtl/sipo_deserializer.sv | 91 +++++++++
 2 files changed

// File: rtl/sipo_deserializer_if.sv
// Serial-in and parallel-out handshake bundle for sipo_deserializer.
// The slave view is the deserializer; the master view is the surrounding logic.
interface sipo_deserializer_if #(
  parameter int WIDTH = 8
) ();
  logic             s_valid;
  logic             s_data;
  logic             s_ready;
  logic             p_valid;
  logic [WIDTH-1:0] p_data;
  logic             p_ready;

  modport slave (
    input  s_valid, s_data, p_ready,
    output s_ready, p_valid, p_data
  );

  modport master (
    output s_valid, s_data, p_ready,
    input  s_ready, p_valid, p_data
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer: a staging shift register feeds a registered
// output word, so bits keep arriving while the consumer holds the last word.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  sipo_deserializer_if.slave    bus,
  output logic [CW-1:0]         bit_count
);

  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             pvalid_q, pvalid_d;

  logic             s_ready;
  logic             accept;
  logic             out_free;
  logic [WIDTH-1:0] nsh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
    end
  end

  always_comb begin
    s_ready  = (cnt_q != FULL);
    accept   = bus.s_valid && s_ready;
    out_free = !pvalid_q || bus.p_ready;
    if (MSB_FIRST) nsh = {sh_q[WIDTH-2:0], bus.s_data};
    else           nsh = {bus.s_data, sh_q[WIDTH-1:1]};
  end

  always_comb begin
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    pdata_d  = pdata_q;
    pvalid_d = pvalid_q;
    if (flush) begin
      sh_d     = '0;
      cnt_d    = '0;
      pvalid_d = 1'b0;
    end else if (cnt_q == FULL) begin
      // Staging holds a finished word stalled behind the output register.
      if (out_free) begin
        pdata_d  = sh_q;
        pvalid_d = 1'b1;
        sh_d     = '0;
        cnt_d    = '0;
      end
    end else if (accept && (cnt_q == LAST)) begin
      if (out_free) begin
        pdata_d  = nsh;
        pvalid_d = 1'b1;
        sh_d     = '0;
        cnt_d    = '0;
      end else begin
        sh_d  = nsh;
        cnt_d = FULL;
      end
    end else begin
      if (accept) begin
        sh_d  = nsh;
        cnt_d = cnt_q + CW'(1);
      end
      if (pvalid_q && bus.p_ready) pvalid_d = 1'b0;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.p_valid = pvalid_q;
  assign bus.p_data  = pdata_q;
  assign bit_count   = cnt_q;

endmodule
